// File: rtl/audio_pkg.sv
// Shared audio definitions: FSM state encoding and default tone-window lengths,
// common to the sound gate and the game-control FSM.
package audio_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CLICK   = 2'd1,
        VICTORY = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam int CLICK_CYCLES_DEF = 2_500_000;
    localparam int VICT_CYCLES_DEF  = 150_000_000;

endpackage

// File: rtl/sound_gate.sv
// Gates the click and victory square waves onto the speaker pin according to game
// events, and holds the victory generator in reset outside the victory window.
module sound_gate
    import audio_pkg::*;
#(
    parameter int CLICK_CYCLES = CLICK_CYCLES_DEF,
    parameter int VICT_CYCLES  = VICT_CYCLES_DEF,
    parameter int CNT_W        = 28
) (
    input  logic clk,
    input  logic rst,
    input  logic point_pulse,
    input  logic win_pulse,
    input  logic new_game,
    input  logic mute,
    input  logic victory_tone,
    input  logic click_tone,
    output logic music_rst,
    output logic speaker,
    output logic busy
);

    localparam logic [CNT_W-1:0] CLICK_LOAD = CNT_W'(CLICK_CYCLES - 1);
    localparam logic [CNT_W-1:0] VICT_LOAD  = CNT_W'(VICT_CYCLES - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             click_tone_q, victory_tone_q;
    logic             music_rst_q, music_rst_d;
    logic             speaker_q, speaker_d;
    logic             busy_q, busy_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (new_game) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (win_pulse) begin
                        state_d = VICTORY;
                        cnt_d   = VICT_LOAD;
                    end else if (point_pulse) begin
                        state_d = CLICK;
                        cnt_d   = CLICK_LOAD;
                    end
                end
                CLICK: begin
                    if (win_pulse) begin
                        state_d = VICTORY;
                        cnt_d   = VICT_LOAD;
                    end else if (point_pulse) begin
                        cnt_d = CLICK_LOAD;
                    end else if (cnt_q == '0) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                VICTORY: begin
                    if (cnt_q == '0) begin
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs are looked ahead from the next state so they line up with state_q.
    always_comb begin
        music_rst_d = (state_d != VICTORY);
        busy_d      = (state_d == CLICK) || (state_d == VICTORY);
        speaker_d   = !mute && (((state_q == CLICK) && click_tone_q) ||
                                ((state_q == VICTORY) && victory_tone_q));
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            click_tone_q   <= 1'b0;
            victory_tone_q <= 1'b0;
            music_rst_q    <= 1'b1;
            speaker_q      <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            click_tone_q   <= click_tone;
            victory_tone_q <= victory_tone;
            music_rst_q    <= music_rst_d;
            speaker_q      <= speaker_d;
            busy_q         <= busy_d;
        end
    end

    assign music_rst = music_rst_q;
    assign speaker   = speaker_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_sound_gate.sv
// Directed scoreboard bench for sound_gate with short windows (click 4, victory 10).
module tb_sound_gate;

    localparam int ST_IDLE = 0;
    localparam int ST_CLK  = 1;
    localparam int ST_VIC  = 2;
    localparam int ST_DONE = 3;

    logic clk = 1'b0;
    logic rst, point_pulse, win_pulse, new_game, mute, victory_tone, click_tone;
    logic music_rst, speaker, busy;

    typedef struct packed {
        logic spk;
        logic bsy;
        logic mrst;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    int   step_no = 0;

    logic tog = 1'b0;
    int   prev_src = ST_IDLE;
    logic prev_ct = 1'b0;
    logic prev_vt = 1'b0;

    sound_gate #(
        .CLICK_CYCLES(4),
        .VICT_CYCLES (10),
        .CNT_W       (28)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .point_pulse (point_pulse),
        .win_pulse   (win_pulse),
        .new_game    (new_game),
        .mute        (mute),
        .victory_tone(victory_tone),
        .click_tone  (click_tone),
        .music_rst   (music_rst),
        .speaker     (speaker),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // One cycle of stimulus; exp_st is the hand-derived state after the coming edge.
    task automatic step(input logic r, input logic pt, input logic wn, input logic ng,
                        input logic mu, input int exp_st);
        exp_t e;
        rst          = r;
        point_pulse  = pt;
        win_pulse    = wn;
        new_game     = ng;
        mute         = mu;
        click_tone   = tog;
        victory_tone = ~tog;
        if (!r) begin
            e.spk  = 1'b0;
            e.bsy  = 1'b0;
            e.mrst = 1'b1;
        end else begin
            e.spk  = !mu && (((prev_src == ST_CLK) && prev_ct) || ((prev_src == ST_VIC) && prev_vt));
            e.bsy  = (exp_st == ST_CLK) || (exp_st == ST_VIC);
            e.mrst = (exp_st != ST_VIC);
        end
        exp_q.push_back(e);
        prev_src = r ? exp_st : ST_IDLE;
        prev_ct  = tog;
        prev_vt  = ~tog;
        tog      = ~tog;
        @(posedge clk);
        @(negedge clk);
        #1;
        step_no++;
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            tests += 3;
            if (speaker !== e.spk) begin
                fails++;
                $display("FAIL speaker step %0d: got %b expected %b", step_no, speaker, e.spk);
            end
            if (busy !== e.bsy) begin
                fails++;
                $display("FAIL busy step %0d: got %b expected %b", step_no, busy, e.bsy);
            end
            if (music_rst !== e.mrst) begin
                fails++;
                $display("FAIL music_rst step %0d: got %b expected %b", step_no, music_rst, e.mrst);
            end
            $display("[TB] step %0d spk=%b busy=%b mrst=%b", step_no, speaker, busy, music_rst);
        end
    end

    initial begin
        rst = 1'b0; point_pulse = 1'b0; win_pulse = 1'b0; new_game = 1'b0;
        mute = 1'b0; click_tone = 1'b0; victory_tone = 1'b1;
        @(negedge clk);
        #1;

        // reset held low for three cycles, then idle
        repeat (3) step(0, 0, 0, 0, 0, ST_IDLE);
        repeat (2) step(1, 0, 0, 0, 0, ST_IDLE);

        // single click: four cycles in CLICK, then back to IDLE
        step(1, 1, 0, 0, 0, ST_CLK);
        repeat (3) step(1, 0, 0, 0, 0, ST_CLK);
        repeat (2) step(1, 0, 0, 0, 0, ST_IDLE);

        // retrigger when cnt==1 extends the window by four more cycles
        step(1, 1, 0, 0, 0, ST_CLK);
        repeat (2) step(1, 0, 0, 0, 0, ST_CLK);
        step(1, 1, 0, 0, 0, ST_CLK);
        repeat (3) step(1, 0, 0, 0, 0, ST_CLK);
        repeat (2) step(1, 0, 0, 0, 0, ST_IDLE);

        // win preempts a click; ten cycles of VICTORY, then DONE ignores events
        step(1, 1, 0, 0, 0, ST_CLK);
        step(1, 0, 1, 0, 0, ST_VIC);
        repeat (9) step(1, 0, 0, 0, 0, ST_VIC);
        step(1, 0, 0, 0, 0, ST_DONE);
        step(1, 1, 0, 0, 0, ST_DONE);
        step(1, 0, 1, 0, 0, ST_DONE);
        step(1, 0, 0, 1, 0, ST_IDLE);

        // point+win together picks VICTORY; new_game+win together aborts to IDLE
        step(1, 1, 1, 0, 0, ST_VIC);
        step(1, 1, 0, 0, 0, ST_VIC);
        step(1, 0, 0, 0, 0, ST_VIC);
        step(1, 0, 1, 1, 0, ST_IDLE);
        step(1, 0, 0, 0, 0, ST_IDLE);

        // muted victory still runs its full window
        step(1, 0, 1, 0, 1, ST_VIC);
        repeat (9) step(1, 0, 0, 0, 1, ST_VIC);
        step(1, 0, 0, 0, 1, ST_DONE);
        step(1, 0, 0, 1, 0, ST_IDLE);

        // reset in the middle of a victory window
        step(1, 0, 1, 0, 0, ST_VIC);
        repeat (3) step(1, 0, 0, 0, 0, ST_VIC);
        step(0, 0, 0, 0, 0, ST_IDLE);
        repeat (2) step(1, 0, 0, 0, 0, ST_IDLE);
        step(1, 1, 0, 0, 0, ST_CLK);
        repeat (3) step(1, 0, 0, 0, 0, ST_CLK);
        step(1, 0, 0, 0, 0, ST_IDLE);

        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
